// File: rtl/reflet_timer_pkg.sv
// Shared register map and CTRL layout for reflet_timer.
// Optional capture register gated by REFLET_TIMER_CAPTURE_EN.
package reflet_timer_pkg;
`include "reflet.vh"

  localparam int REG_CTRL  = `REFLET_TIMER_CTRL;
  localparam int REG_PRESC = `REFLET_TIMER_PRESC;
  localparam int REG_CMP   = `REFLET_TIMER_CMP;
  localparam int REG_COUNT = `REFLET_TIMER_COUNT;
  localparam int REG_CAPT  = `REFLET_TIMER_CAPT;

  localparam int CTRL_EN   = `REFLET_TIMER_CTRL_EN;
  localparam int CTRL_AUTO = `REFLET_TIMER_CTRL_AUTO;
  localparam int CTRL_IE   = `REFLET_TIMER_CTRL_IE;
  localparam int CTRL_PEND = `REFLET_TIMER_CTRL_PEND;
  localparam int CTRL_CAPF = `REFLET_TIMER_CTRL_CAPF;

`ifdef REFLET_TIMER_CAPTURE_EN
  localparam int NUM_REGS = 5;
`else
  localparam int NUM_REGS = 4;
`endif

  // Field order matches the CTRL bit positions above (en is bit 0).
  typedef struct packed {
    logic capf;
    logic pend;
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/reflet.vh
// Reflet timer register indices and CTRL bit positions.
`ifndef REFLET_VH
`define REFLET_VH

`define REFLET_TIMER_CTRL   0
`define REFLET_TIMER_PRESC  1
`define REFLET_TIMER_CMP    2
`define REFLET_TIMER_COUNT  3
`define REFLET_TIMER_CAPT   4

`define REFLET_TIMER_CTRL_EN   0
`define REFLET_TIMER_CTRL_AUTO 1
`define REFLET_TIMER_CTRL_IE   2
`define REFLET_TIMER_CTRL_PEND 3
`define REFLET_TIMER_CTRL_CAPF 4

`endif

// File: rtl/reflet_timer_prescaler.sv
// Prescaler: counts 0..reload while enabled, single-cycle tick on reaching reload.
module reflet_timer_prescaler #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [wordsize-1:0] reload,
  output logic                tick
);

  logic [wordsize-1:0] cnt_q;

  assign tick = en && (cnt_q == reload);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + wordsize'(1);
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped compare timer on the Reflet bus; registered read data, level irq.
// Define REFLET_TIMER_CAPTURE_EN to add the capture_in synchroniser and CAPT register.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int                  wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = wordsize'(16'hFF00)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq,
  input  logic                capture_in
);

  localparam logic [wordsize-1:0] STEP = wordsize'(wordsize / 8);

  ctrl_t               ctrl_q, ctrl_d;
  logic [wordsize-1:0] presc_q, presc_d;
  logic [wordsize-1:0] cmp_q, cmp_d;
  logic [wordsize-1:0] count_q, count_d;
  logic [wordsize-1:0] rd_val;
  logic                irq_d;
  logic                hit;
  logic [2:0]          idx;
  logic                wr_ctrl, wr_presc, wr_cmp, wr_count;
  logic                tick, match, presc_clr;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr == base_addr + STEP * wordsize'(k)) begin
        hit = 1'b1;
        idx = 3'(k);
      end
    end
  end

  assign wr_ctrl  = write_en && hit && (idx == 3'(REG_CTRL));
  assign wr_presc = write_en && hit && (idx == 3'(REG_PRESC));
  assign wr_cmp   = write_en && hit && (idx == 3'(REG_CMP));
  assign wr_count = write_en && hit && (idx == 3'(REG_COUNT));

  // Restart the prescale period whenever software re-arms or reloads the timer.
  assign presc_clr = wr_presc || wr_count || (wr_ctrl && data_in[CTRL_EN] && !ctrl_q.en);

  reflet_timer_prescaler #(.wordsize(wordsize)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_q.en),
    .clr    (presc_clr),
    .reload (presc_q),
    .tick   (tick)
  );

  assign match = tick && (count_q == cmp_q);

`ifdef REFLET_TIMER_CAPTURE_EN
  logic [2:0]          cap_sync_q;
  logic [wordsize-1:0] capt_q, capt_d;
  logic                cap_rise;

  assign cap_rise = cap_sync_q[1] && !cap_sync_q[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_sync_q <= '0;
      capt_q     <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], capture_in};
      capt_q     <= capt_d;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture_in;
`endif

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    count_d = count_q;
`ifdef REFLET_TIMER_CAPTURE_EN
    capt_d  = capt_q;
`endif

    if (tick) begin
      if (match) begin
        ctrl_d.pend = 1'b1;
        if (ctrl_q.auto_rl) count_d = '0;
        else                ctrl_d.en = 1'b0;
      end else begin
        count_d = count_q + wordsize'(1);
      end
    end

`ifdef REFLET_TIMER_CAPTURE_EN
    // Captures the pre-write COUNT, so a coincident COUNT write does not leak in.
    if (cap_rise) begin
      capt_d      = count_q;
      ctrl_d.capf = 1'b1;
    end
`endif

    // Software writes override timer events, except that flag sets beat flag clears.
    if (wr_ctrl) begin
      ctrl_d.en      = data_in[CTRL_EN];
      ctrl_d.auto_rl = data_in[CTRL_AUTO];
      ctrl_d.ie      = data_in[CTRL_IE];
      if (data_in[CTRL_PEND] && !match) ctrl_d.pend = 1'b0;
`ifdef REFLET_TIMER_CAPTURE_EN
      if (data_in[CTRL_CAPF] && !cap_rise) ctrl_d.capf = 1'b0;
`else
      if (data_in[CTRL_CAPF]) ctrl_d.capf = 1'b0;
`endif
    end
    if (wr_presc) presc_d = data_in;
    if (wr_cmp)   cmp_d   = data_in;
    if (wr_count) count_d = data_in;
  end

`ifdef REFLET_TIMER_CAPTURE_EN
  assign irq_d = (ctrl_d.pend || ctrl_d.capf) && ctrl_d.ie;
`else
  assign irq_d = ctrl_d.pend && ctrl_d.ie;
`endif

  always_comb begin
    rd_val = '0;
    if (hit) begin
      if (idx == 3'(REG_CTRL))       rd_val[4:0] = ctrl_q;
      else if (idx == 3'(REG_PRESC)) rd_val = presc_q;
      else if (idx == 3'(REG_CMP))   rd_val = cmp_q;
      else if (idx == 3'(REG_COUNT)) rd_val = count_q;
`ifdef REFLET_TIMER_CAPTURE_EN
      else if (idx == 3'(REG_CAPT))  rd_val = capt_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      cmp_q    <= '0;
      count_q  <= '0;
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      cmp_q    <= cmp_d;
      count_q  <= count_d;
      data_out <= rd_val;
      irq      <= irq_d;
    end
  end

endmodule

// File: tb/tb_reflet_timer.sv
// Randomised and directed bench for reflet_timer against a behavioural register model.
module tb_reflet_timer;

  localparam logic [15:0] BASE = 16'hFF00;
`ifdef REFLET_TIMER_CAPTURE_EN
  localparam int NR = 5;
`else
  localparam int NR = 4;
`endif

  logic        clk, reset, write_en, irq, capture_in;
  logic [15:0] addr, data_in, data_out;

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 1'b1;

  reflet_timer #(.wordsize(16), .base_addr(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data_in    (data_in),
    .write_en   (write_en),
    .data_out   (data_out),
    .irq        (irq),
    .capture_in (capture_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: registers as the software sees them.
  logic        m_en, m_auto, m_ie, m_pend, m_capf;
  logic [15:0] m_presc, m_cmp, m_count, m_capt, m_pcnt, m_dout;
  logic        m_irq;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ra(input int k);
    return BASE + 16'(2 * k);
  endfunction

  function automatic int reg_of(input logic [15:0] a);
    for (int k = 0; k < NR; k++)
      if (a == ra(k)) return k;
    return -1;
  endfunction

  task automatic m_reset();
    {m_en, m_auto, m_ie, m_pend, m_capf, m_irq} = '0;
    m_presc = 0; m_cmp = 0; m_count = 0; m_capt = 0; m_pcnt = 0; m_dout = 0;
  endtask

  task automatic m_edge(input logic [15:0] a, input logic [15:0] d, input logic we);
    int   k;
    logic tick, match, old_en;
    k = reg_of(a);
    case (k)
      0:       m_dout = {11'b0, m_capf, m_pend, m_ie, m_auto, m_en};
      1:       m_dout = m_presc;
      2:       m_dout = m_cmp;
      3:       m_dout = m_count;
      4:       m_dout = m_capt;
      default: m_dout = 16'h0;
    endcase
    old_en = m_en;
    tick   = m_en && (m_pcnt == m_presc);
    match  = tick && (m_count == m_cmp);
    if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    if (match) begin
      m_pend = 1'b1;
      if (m_auto) m_count = 16'd0;
      else        m_en = 1'b0;
    end else if (tick) begin
      m_count = m_count + 16'd1;
    end
    if (we) begin
      case (k)
        0: begin
          m_en = d[0]; m_auto = d[1]; m_ie = d[2];
          if (d[3] && !match) m_pend = 1'b0;
          if (d[4]) m_capf = 1'b0;
          if (d[0] && !old_en) m_pcnt = 16'd0;
        end
        1: begin m_presc = d; m_pcnt = 16'd0; end
        2: m_cmp = d;
        3: begin m_count = d; m_pcnt = 16'd0; end
        default: ;
      endcase
    end
    m_irq = (m_pend || m_capf) && m_ie;
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we);
    addr = a; data_in = d; write_en = we;
    @(posedge clk);
    m_edge(a, d, we);
    #1;
    if (model_on) begin
      chk("model_dout", data_out, m_dout);
      chk("model_irq", 16'(irq), 16'(m_irq));
    end
    write_en = 1'b0;
  endtask

  task automatic wr(input int k, input logic [15:0] d);
    step(ra(k), d, 1'b1);
  endtask

  task automatic idle();
    step(16'h0000, 16'h0, 1'b0);
  endtask

  task automatic wait_irq(input int lim, output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!irq && n < lim);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", data_out, 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a, d;
    reset = 1'b0; addr = 0; data_in = 0; write_en = 0; capture_in = 0;
    m_reset();
    do_reset();

    for (int k = 0; k < 4; k++) begin
      step(ra(k), 16'h0, 1'b0);
      chk("rd_after_reset", data_out, 16'h0);
    end
    step(BASE + 16'h0010, 16'h0, 1'b0);
    chk("rd_undecoded", data_out, 16'h0);

    // Auto-reload period: 6 ticks of 4 cycles.
    wr(1, 16'd3); wr(2, 16'd5); wr(0, 16'h0007);
    wait_irq(100, n);
    chk("auto_first_irq", 16'(n), 16'd24);
    step(ra(3), 16'h0, 1'b0);
    chk("auto_count_reload", data_out, 16'h0);
    wr(0, 16'h000F);
    chk("auto_pend_clear", 16'(irq), 16'h0);
    wait_irq(100, n);
    chk("auto_period", 16'(n), 16'd22);

    // One-shot.
    wr(0, 16'h0008); wr(3, 16'h0); wr(1, 16'h0); wr(2, 16'd2); wr(0, 16'h0005);
    wait_irq(20, n);
    chk("oneshot_irq", 16'(n), 16'd3);
    step(ra(0), 16'h0, 1'b0);
    chk("oneshot_ctrl", data_out, 16'h000C);
    idle(); idle();
    step(ra(3), 16'h0, 1'b0);
    chk("oneshot_count_hold", data_out, 16'd2);

    // PEND set beats a coincident clear.
    wr(3, 16'h0); wr(0, 16'h000F); idle(); idle();
    wr(0, 16'h000F);
    chk("set_wins_irq", 16'(irq), 16'h1);
    wr(0, 16'h0008);
    chk("later_clear_irq", 16'(irq), 16'h0);
    step(ra(0), 16'h0, 1'b0);
    chk("later_clear_ctrl", data_out, 16'h0);

    // COUNT write beats a coincident tick; then wrap without flag.
    wr(1, 16'h0); wr(2, 16'hFFFF); wr(0, 16'h0007); wr(3, 16'h0010);
    step(ra(3), 16'h0, 1'b0);
    chk("count_write_wins", data_out, 16'h0010);
    wr(2, 16'd5); wr(3, 16'hFFFE); idle(); idle();
    step(ra(3), 16'h0, 1'b0);
    chk("wrap_count", data_out, 16'h0);
    chk("wrap_no_irq", 16'(irq), 16'h0);
    wait_irq(20, n);
    chk("wrap_then_match", 16'(n), 16'd5);

    // Asynchronous reset mid-count.
    step(ra(0), 16'h0, 1'b0);
    chk("pre_reset_ctrl", data_out, 16'h000F);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_dout", data_out, 16'h0);
    chk("async_rst_irq", 16'(irq), 16'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(ra(k), 16'h0, 1'b0);
      chk("rd_after_async_rst", data_out, 16'h0);
    end

`ifdef REFLET_TIMER_CAPTURE_EN
    model_on = 1'b0;
    wr(3, 16'd7); wr(0, 16'h0004);
    capture_in = 1'b1;
    idle();
    capture_in = 1'b0;
    wait_irq(10, n);
    chk("capt_latency_ok", 16'(n <= 4), 16'h1);
    chk("capt_irq", 16'(irq), 16'h1);
    step(ra(4), 16'h0, 1'b0);
    chk("capt_value", data_out, 16'd7);
    step(ra(0), 16'h0, 1'b0);
    chk("capt_ctrl", data_out, 16'h0014);
    wr(0, 16'h0010);
    chk("capf_clear_irq", 16'(irq), 16'h0);
    model_on = 1'b1;
    do_reset();
`endif

    // Randomised register traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom % 8)
        0: a = ra(0);
        1: a = ra(1);
        2: a = ra(2);
        3: a = ra(3);
        4: a = ra(3);
        5: a = ra(4);
        6: a = BASE + 16'h0001;
        default: a = 16'($urandom);
      endcase
      case (reg_of(a))
        0: d = 16'($urandom % 32);
        1: d = 16'($urandom % 4);
        2: d = 16'($urandom % 12);
        3: d = (($urandom % 8) == 0) ? 16'hFFFE : 16'($urandom % 12);
        default: d = 16'($urandom);
      endcase
      step(a, d, ($urandom % 10) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
